// File: rtl/msrv32_pkg.sv
// Shared constants for the msrv32 machine-mode trap controller.
// State, PC-source and cause encodings plus SYSTEM decode fields.
package msrv32_pkg;

  localparam logic [1:0] ST_RESET       = 2'b00;
  localparam logic [1:0] ST_OPERATING   = 2'b01;
  localparam logic [1:0] ST_TRAP_TAKEN  = 2'b10;
  localparam logic [1:0] ST_TRAP_RETURN = 2'b11;

  localparam logic [1:0] PC_BOOT = 2'b00;
  localparam logic [1:0] PC_NEXT = 2'b01;
  localparam logic [1:0] PC_TRAP = 2'b10;
  localparam logic [1:0] PC_EPC  = 2'b11;

  localparam logic [3:0] CAUSE_MIS_INSTR = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK    = 4'd3;
  localparam logic [3:0] CAUSE_MIS_LOAD  = 4'd4;
  localparam logic [3:0] CAUSE_MIS_STORE = 4'd6;
  localparam logic [3:0] CAUSE_ECALL     = 4'd11;
  localparam logic [3:0] CAUSE_M_SW_IRQ  = 4'd3;
  localparam logic [3:0] CAUSE_M_TMR_IRQ = 4'd7;
  localparam logic [3:0] CAUSE_M_EXT_IRQ = 4'd11;

  localparam logic [4:0] OP_SYSTEM  = 5'b11100;
  localparam logic [6:0] F7_MRET    = 7'b0011000;
  localparam logic [4:0] RS2_MRET   = 5'b00010;
  localparam logic [4:0] RS2_EBREAK = 5'b00001;

endpackage

// File: rtl/msrv32_trap_prioritiser.sv
// Combinational trap encoder: decodes SYSTEM instructions and
// picks the highest-priority exception or interrupt cause.
module msrv32_trap_prioritiser
  import msrv32_pkg::*;
(
  input  logic       i_illegal,
  input  logic       i_mis_load,
  input  logic       i_mis_store,
  input  logic       i_mis_instr,
  input  logic [4:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  input  logic [4:0] i_rd,
  input  logic       i_mie,
  input  logic       i_meie,
  input  logic       i_mtie,
  input  logic       i_msie,
  input  logic       i_meip,
  input  logic       i_mtip,
  input  logic       i_msip,
  output logic       o_exception,
  output logic       o_irq,
  output logic       o_mret,
  output logic       o_i_or_e,
  output logic       o_misaligned,
  output logic [3:0] o_cause
);

  logic w_sys;
  logic w_ecall;
  logic w_ebreak;
  logic w_ext;
  logic w_sw;
  logic w_tmr;

  assign w_sys = (i_opcode == OP_SYSTEM) && (i_funct3 == 3'b000)
              && (i_rs1 == 5'd0) && (i_rd == 5'd0);

  assign w_ecall  = w_sys && (i_funct7 == 7'd0) && (i_rs2 == 5'd0);
  assign w_ebreak = w_sys && (i_funct7 == 7'd0) && (i_rs2 == RS2_EBREAK);
  assign o_mret   = w_sys && (i_funct7 == F7_MRET) && (i_rs2 == RS2_MRET);

  assign w_ext = i_mie & i_meie & i_meip;
  assign w_sw  = i_mie & i_msie & i_msip;
  assign w_tmr = i_mie & i_mtie & i_mtip;

  assign o_exception = i_mis_instr | i_illegal | w_ecall | w_ebreak
                     | i_mis_load | i_mis_store;
  assign o_irq = w_ext | w_sw | w_tmr;

  // Exceptions always win; within each class a fixed priority order.
  always_comb begin
    o_cause      = 4'd0;
    o_i_or_e     = 1'b0;
    o_misaligned = 1'b0;
    if (i_mis_instr) begin
      o_cause      = CAUSE_MIS_INSTR;
      o_misaligned = 1'b1;
    end else if (i_illegal) begin
      o_cause = CAUSE_ILLEGAL;
    end else if (w_ecall) begin
      o_cause = CAUSE_ECALL;
    end else if (w_ebreak) begin
      o_cause = CAUSE_EBREAK;
    end else if (i_mis_load) begin
      o_cause      = CAUSE_MIS_LOAD;
      o_misaligned = 1'b1;
    end else if (i_mis_store) begin
      o_cause      = CAUSE_MIS_STORE;
      o_misaligned = 1'b1;
    end else if (w_ext) begin
      o_cause  = CAUSE_M_EXT_IRQ;
      o_i_or_e = 1'b1;
    end else if (w_sw) begin
      o_cause  = CAUSE_M_SW_IRQ;
      o_i_or_e = 1'b1;
    end else if (w_tmr) begin
      o_cause  = CAUSE_M_TMR_IRQ;
      o_i_or_e = 1'b1;
    end
  end

endmodule

// File: rtl/msrv32_machine_control.sv
// Machine-mode trap/return FSM for the single-cycle RV32I core.
// Drives PC source, fetch flush and CSR-file trap strobes.
module msrv32_machine_control
  import msrv32_pkg::*;
#(
  parameter int CAUSE_W   = 4,
  parameter int BOOT_HOLD = 1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               illegal_instr_in,
  input  logic               misaligned_load_in,
  input  logic               misaligned_store_in,
  input  logic               misaligned_instr_in,
  input  logic [4:0]         opcode_6_to_2_in,
  input  logic [2:0]         funct3_in,
  input  logic [6:0]         funct7_in,
  input  logic [4:0]         rs1_addr_in,
  input  logic [4:0]         rs2_addr_in,
  input  logic [4:0]         rd_addr_in,
  input  logic               mie_in,
  input  logic               meie_in,
  input  logic               mtie_in,
  input  logic               msie_in,
  input  logic               meip_in,
  input  logic               mtip_in,
  input  logic               msip_in,
  output logic [1:0]         pc_src_out,
  output logic               flush_out,
  output logic               trap_taken_out,
  output logic               i_or_e_out,
  output logic [CAUSE_W-1:0] cause_out,
  output logic               set_cause_out,
  output logic               set_epc_out,
  output logic               mie_clear_out,
  output logic               mie_set_out,
  output logic               misaligned_exception_out,
  output logic               instret_inc_out
);

  localparam logic [1:0] HOLD_LAST = 2'(BOOT_HOLD - 1);

  logic [1:0]         r_state;
  logic [1:0]         r_hold;
  logic [CAUSE_W-1:0] r_cause;
  logic               r_i_or_e;
  logic               r_mis;

  logic       w_exception;
  logic       w_irq;
  logic       w_mret;
  logic       w_i_or_e;
  logic       w_mis;
  logic [3:0] w_cause;
  logic       w_op;

  msrv32_trap_prioritiser u_prio (
    .i_illegal    (illegal_instr_in),
    .i_mis_load   (misaligned_load_in),
    .i_mis_store  (misaligned_store_in),
    .i_mis_instr  (misaligned_instr_in),
    .i_opcode     (opcode_6_to_2_in),
    .i_funct3     (funct3_in),
    .i_funct7     (funct7_in),
    .i_rs1        (rs1_addr_in),
    .i_rs2        (rs2_addr_in),
    .i_rd         (rd_addr_in),
    .i_mie        (mie_in),
    .i_meie       (meie_in),
    .i_mtie       (mtie_in),
    .i_msie       (msie_in),
    .i_meip       (meip_in),
    .i_mtip       (mtip_in),
    .i_msip       (msip_in),
    .o_exception  (w_exception),
    .o_irq        (w_irq),
    .o_mret       (w_mret),
    .o_i_or_e     (w_i_or_e),
    .o_misaligned (w_mis),
    .o_cause      (w_cause)
  );

  assign w_op = (r_state == ST_OPERATING);

  // State, boot-hold counter and trap-cause capture.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state  <= ST_RESET;
      r_hold   <= 2'd0;
      r_cause  <= '0;
      r_i_or_e <= 1'b0;
      r_mis    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_RESET: begin
          if (r_hold == HOLD_LAST) begin
            r_state <= ST_OPERATING;
            r_hold  <= 2'd0;
          end else begin
            r_hold <= r_hold + 2'd1;
          end
        end
        ST_OPERATING: begin
          if (w_exception || w_irq) begin
            r_state  <= ST_TRAP_TAKEN;
            r_cause  <= CAUSE_W'(w_cause);
            r_i_or_e <= w_i_or_e;
            r_mis    <= w_mis;
          end else if (w_mret) begin
            r_state <= ST_TRAP_RETURN;
          end
        end
        ST_TRAP_TAKEN:  r_state <= ST_OPERATING;
        ST_TRAP_RETURN: r_state <= ST_OPERATING;
        default:        r_state <= ST_RESET;
      endcase
    end
  end

  // Per-state PC source, flush and CSR strobes.
  always_comb begin
    pc_src_out     = PC_BOOT;
    flush_out      = 1'b1;
    trap_taken_out = 1'b0;
    set_cause_out  = 1'b0;
    set_epc_out    = 1'b0;
    mie_clear_out  = 1'b0;
    mie_set_out    = 1'b0;
    unique case (r_state)
      ST_RESET: begin
        pc_src_out = PC_BOOT;
        flush_out  = 1'b1;
      end
      ST_OPERATING: begin
        pc_src_out = PC_NEXT;
        flush_out  = 1'b0;
      end
      ST_TRAP_TAKEN: begin
        pc_src_out     = PC_TRAP;
        trap_taken_out = 1'b1;
        set_cause_out  = 1'b1;
        set_epc_out    = 1'b1;
        mie_clear_out  = 1'b1;
      end
      ST_TRAP_RETURN: begin
        pc_src_out  = PC_EPC;
        mie_set_out = 1'b1;
      end
      default: begin
        pc_src_out = PC_BOOT;
      end
    endcase
  end

  assign instret_inc_out = w_op & ~w_exception & ~w_irq;

  assign cause_out                = r_cause;
  assign i_or_e_out               = r_i_or_e;
  assign misaligned_exception_out = r_mis;

endmodule

// File: tb/tb_msrv32_machine_control.sv
// Directed bench for msrv32_machine_control.
// Hand-computed expectations checked with immediate assertions.
module tb_msrv32_machine_control;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       illegal_instr_in;
  logic       misaligned_load_in;
  logic       misaligned_store_in;
  logic       misaligned_instr_in;
  logic [4:0] opcode_6_to_2_in;
  logic [2:0] funct3_in;
  logic [6:0] funct7_in;
  logic [4:0] rs1_addr_in;
  logic [4:0] rs2_addr_in;
  logic [4:0] rd_addr_in;
  logic       mie_in, meie_in, mtie_in, msie_in;
  logic       meip_in, mtip_in, msip_in;
  logic [1:0] pc_src_out;
  logic       flush_out;
  logic       trap_taken_out;
  logic       i_or_e_out;
  logic [3:0] cause_out;
  logic       set_cause_out;
  logic       set_epc_out;
  logic       mie_clear_out;
  logic       mie_set_out;
  logic       misaligned_exception_out;
  logic       instret_inc_out;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_in = ~clk_in;

  msrv32_machine_control #(.CAUSE_W(4), .BOOT_HOLD(1)) dut (
    .clk_in                   (clk_in),
    .rst_in                   (rst_in),
    .illegal_instr_in         (illegal_instr_in),
    .misaligned_load_in       (misaligned_load_in),
    .misaligned_store_in      (misaligned_store_in),
    .misaligned_instr_in      (misaligned_instr_in),
    .opcode_6_to_2_in         (opcode_6_to_2_in),
    .funct3_in                (funct3_in),
    .funct7_in                (funct7_in),
    .rs1_addr_in              (rs1_addr_in),
    .rs2_addr_in              (rs2_addr_in),
    .rd_addr_in               (rd_addr_in),
    .mie_in                   (mie_in),
    .meie_in                  (meie_in),
    .mtie_in                  (mtie_in),
    .msie_in                  (msie_in),
    .meip_in                  (meip_in),
    .mtip_in                  (mtip_in),
    .msip_in                  (msip_in),
    .pc_src_out               (pc_src_out),
    .flush_out                (flush_out),
    .trap_taken_out           (trap_taken_out),
    .i_or_e_out               (i_or_e_out),
    .cause_out                (cause_out),
    .set_cause_out            (set_cause_out),
    .set_epc_out              (set_epc_out),
    .mie_clear_out            (mie_clear_out),
    .mie_set_out              (mie_set_out),
    .misaligned_exception_out (misaligned_exception_out),
    .instret_inc_out          (instret_inc_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] ins);
    logic [31:0] w;
    w                = ins;
    opcode_6_to_2_in = w[6:2];
    rd_addr_in       = w[11:7];
    funct3_in        = w[14:12];
    rs1_addr_in      = w[19:15];
    rs2_addr_in      = w[24:20];
    funct7_in        = w[31:25];
  endtask

  task automatic clr_faults();
    illegal_instr_in    = 1'b0;
    misaligned_load_in  = 1'b0;
    misaligned_store_in = 1'b0;
    misaligned_instr_in = 1'b0;
  endtask

  task automatic clr_irq();
    mie_in  = 1'b0;
    meie_in = 1'b0;
    mtie_in = 1'b0;
    msie_in = 1'b0;
    meip_in = 1'b0;
    mtip_in = 1'b0;
    msip_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1;
    clr_faults();
    clr_irq();
    set_instr(32'h00000013);
    repeat (3) step();
    chk("rst_pc", pc_src_out, 2'b00);
    chk("rst_flush", flush_out, 1);
    chk("rst_cause", cause_out, 0);
    chk("rst_ioe", i_or_e_out, 0);
    chk("rst_instret", instret_inc_out, 0);

    rst_in = 1'b0;
    #1;
    chk("boot_pc", pc_src_out, 2'b00);
    chk("boot_flush", flush_out, 1);
    step();
    chk("op_pc", pc_src_out, 2'b01);
    chk("op_flush", flush_out, 0);
    chk("op_instret", instret_inc_out, 1);

    illegal_instr_in = 1'b1;
    #1;
    chk("ill_instret", instret_inc_out, 0);
    step();
    clr_faults();
    #1;
    chk("ill_pc", pc_src_out, 2'b10);
    chk("ill_cause", cause_out, 2);
    chk("ill_ioe", i_or_e_out, 0);
    chk("ill_setc", set_cause_out, 1);
    chk("ill_sete", set_epc_out, 1);
    chk("ill_mclr", mie_clear_out, 1);
    chk("ill_tt", trap_taken_out, 1);
    chk("ill_flush", flush_out, 1);
    chk("ill_instret2", instret_inc_out, 0);
    step();
    chk("ill_back_pc", pc_src_out, 2'b01);
    chk("ill_hold_cause", cause_out, 2);

    mie_in = 1'b1;
    meie_in = 1'b1;
    meip_in = 1'b1;
    mtie_in = 1'b1;
    mtip_in = 1'b1;
    misaligned_load_in = 1'b1;
    step();
    clr_faults();
    #1;
    chk("ld_pc", pc_src_out, 2'b10);
    chk("ld_cause", cause_out, 4);
    chk("ld_ioe", i_or_e_out, 0);
    chk("ld_mis", misaligned_exception_out, 1);
    step();
    chk("ld_back_pc", pc_src_out, 2'b01);
    step();
    chk("ext_pc", pc_src_out, 2'b10);
    chk("ext_cause", cause_out, 11);
    chk("ext_ioe", i_or_e_out, 1);
    chk("ext_mis", misaligned_exception_out, 0);
    clr_irq();
    step();
    chk("ext_back_pc", pc_src_out, 2'b01);

    set_instr(32'h30200073);
    #1;
    chk("mret_instret", instret_inc_out, 1);
    step();
    set_instr(32'h00000013);
    #1;
    chk("mret_pc", pc_src_out, 2'b11);
    chk("mret_mset", mie_set_out, 1);
    chk("mret_flush", flush_out, 1);
    chk("mret_tt", trap_taken_out, 0);
    step();
    chk("mret_back_pc", pc_src_out, 2'b01);

    set_instr(32'h00000073);
    step();
    set_instr(32'h00000013);
    #1;
    chk("ecall_cause", cause_out, 11);
    chk("ecall_ioe", i_or_e_out, 0);
    step();

    set_instr(32'h00100073);
    step();
    set_instr(32'h00000013);
    #1;
    chk("ebrk_cause", cause_out, 3);
    chk("ebrk_pc", pc_src_out, 2'b10);
    step();

    set_instr(32'h10500073);
    #1;
    chk("wfi_instret", instret_inc_out, 1);
    step();
    set_instr(32'h00000013);
    #1;
    chk("wfi_pc", pc_src_out, 2'b01);

    misaligned_store_in = 1'b1;
    misaligned_instr_in = 1'b1;
    step();
    clr_faults();
    #1;
    chk("mi_cause", cause_out, 0);
    chk("mi_mis", misaligned_exception_out, 1);
    step();
    misaligned_store_in = 1'b1;
    step();
    clr_faults();
    #1;
    chk("st_cause", cause_out, 6);
    chk("st_mis", misaligned_exception_out, 1);
    step();

    illegal_instr_in = 1'b1;
    step();
    clr_faults();
    rst_in = 1'b1;
    #1;
    chk("trst_pre_pc", pc_src_out, 2'b10);
    step();
    chk("trst_pc", pc_src_out, 2'b00);
    chk("trst_cause", cause_out, 0);
    chk("trst_mclr", mie_clear_out, 0);
    chk("trst_tt", trap_taken_out, 0);
    chk("trst_flush", flush_out, 1);
    rst_in = 1'b0;
    step();
    chk("trst_op_pc", pc_src_out, 2'b01);

    set_instr(32'h30200073);
    step();
    set_instr(32'h00000013);
    mie_in  = 1'b1;
    msie_in = 1'b1;
    msip_in = 1'b1;
    #1;
    chk("tr_irq_pc", pc_src_out, 2'b11);
    step();
    chk("tr_irq_op_pc", pc_src_out, 2'b01);
    chk("tr_irq_instret", instret_inc_out, 0);
    step();
    chk("sw_pc", pc_src_out, 2'b10);
    chk("sw_cause", cause_out, 3);
    chk("sw_ioe", i_or_e_out, 1);
    clr_irq();
    step();
    chk("sw_back_pc", pc_src_out, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/msrv32_machine_control.md
Name: msrv32_machine_control

Overview:
- Machine-mode trap/return controller for the single-cycle RV32I core.
- Sits beside the decoder and consumes its illegal_instr and misaligned_load/store flags plus raw instruction fields.
- Drives trap_taken back into the decoder, selects the PC source and flushes the fetch path.
- Sequences the CSR file through trap entry (cause/epc capture, MIE clear) and MRET (MIE restore).

Parameters:
- CAUSE_W, 4, width of cause_out (mcause exception-code field).
- BOOT_HOLD, 1, cycles spent in RESET state after rst_in deasserts (1..3).

Ports:
- clk_in  input  1  core clock; all state updates on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- illegal_instr_in  input  1  from decoder.
- misaligned_load_in  input  1  from decoder.
- misaligned_store_in  input  1  from decoder.
- misaligned_instr_in  input  1  target PC[1:0]!=0 from branch/jump unit.
- opcode_6_to_2_in  input  5  instruction[6:2].
- funct3_in  input  3  instruction[14:12].
- funct7_in  input  7  instruction[31:25].
- rs1_addr_in, rs2_addr_in, rd_addr_in  input  5 each  instruction fields.
- mie_in  input  1  mstatus.MIE.
- meie_in, mtie_in, msie_in  input  1 each  mie register enables.
- meip_in, mtip_in, msip_in  input  1 each  pending lines.
- pc_src_out  output  2  00 boot, 01 next-PC, 10 trap vector, 11 mepc.
- flush_out  output  1  squash instruction in fetch register.
- trap_taken_out  output  1  to decoder trap_taken_in.
- i_or_e_out  output  1  1 = interrupt, 0 = exception.
- cause_out  output  CAUSE_W  exception code.
- set_cause_out, set_epc_out, mie_clear_out, mie_set_out  output  1 each  CSR-file strobes.
- misaligned_exception_out  output  1  select mtval = faulting address.
- instret_inc_out  output  1  minstret increment.

Behaviour:
- States: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN.
- State-derived outputs are combinational from the state register:
  - RESET: pc_src=00, flush=1.
  - OPERATING: pc_src=01, flush=0.
  - TRAP_TAKEN: pc_src=10, flush=1, trap_taken=1, set_cause=1, set_epc=1, mie_clear=1.
  - TRAP_RETURN: pc_src=11, flush=1, mie_set=1.
- Reset: rst_in=1 at an edge forces RESET, clears the hold counter, i_or_e_out=0, cause_out=0, misaligned_exception_out=0. This holds mid-trap as well. All strobes are 0 except flush=1 and pc_src=00.
- RESET -> OPERATING after BOOT_HOLD cycles with rst_in low.
- Instruction decode, only when opcode_6_to_2_in=11100, funct3=000, rs1=0 and rd=0:
  - ECALL: funct7=0, rs2=0.
  - EBREAK: funct7=0, rs2=1.
  - MRET: funct7=0011000, rs2=00010.
  - WFI: treated as a NOP.
- exception = misaligned_instr | illegal | ecall | ebreak | misaligned_load | misaligned_store.
- irq = mie_in & ((meie&meip) | (msie&msip) | (mtie&mtip)).
- OPERATING transitions, in priority order:
  - exception -> TRAP_TAKEN.
  - else irq -> TRAP_TAKEN.
  - else MRET -> TRAP_RETURN.
  - else stay.
- Exception cause priority: misaligned_instr=0 > illegal=2 > ecall=11 > ebreak=3 > misaligned_load=4 > misaligned_store=6.
- Interrupt cause priority: external=11 > software=3 > timer=7.
- Exception always beats a simultaneous interrupt.
- cause_out, i_or_e_out and misaligned_exception_out are registered on the OPERATING->TRAP_TAKEN edge and stable through TRAP_TAKEN. misaligned_exception_out=1 for causes 0, 4 and 6. These outputs hold their value otherwise.
- TRAP_TAKEN -> OPERATING and TRAP_RETURN -> OPERATING unconditionally, 1 cycle each. Trap entry and return latency is therefore exactly 1 cycle.
- Interrupts and exceptions are ignored outside OPERATING; the inputs are not latched.
- instret_inc_out=1 in OPERATING when neither exception nor irq is true. MRET retires and counts; a trapping instruction does not.

Decomposition:
- Package msrv32_pkg holds:
  - state encodings (RESET=00, OPERATING=01, TRAP_TAKEN=10, TRAP_RETURN=11);
  - pc_src encodings;
  - cause codes;
  - the SYSTEM opcode constant and the MRET funct7/rs2 constants.
- One sub-module, msrv32_trap_prioritiser: combinational encoder producing exception, irq, i_or_e and cause from the flags and the SYSTEM decode.
- The FSM, hold counter and capture registers stay in msrv32_machine_control.

Test Plan:
- Reset, BOOT_HOLD=1: hold rst_in 3 cycles, release -> one RESET cycle (pc_src=00, flush=1), then OPERATING with pc_src=01 and instret_inc=1 on a NOP.
- illegal_instr_in=1 for one cycle in OPERATING -> next cycle TRAP_TAKEN: pc_src=10, cause=2, i_or_e=0, set_cause=set_epc=mie_clear=trap_taken=1, instret_inc=0. Cycle after: OPERATING.
- mie=1, meie=meip=1, mtie=mtip=1 plus misaligned_load_in=1 in the same cycle -> cause=4, i_or_e=0, misaligned_exception=1. Repeat without the load fault -> cause=11, i_or_e=1.
- MRET encoding (0x30200073 fields) -> TRAP_RETURN for 1 cycle: pc_src=11, mie_set=1, flush=1, instret_inc=1 in the issuing cycle.
- ECALL (0x00000073) -> cause=11, i_or_e=0. EBREAK (0x00100073) -> cause=3. WFI (0x10500073) -> stays OPERATING.
- Assert rst_in during TRAP_TAKEN -> next state RESET, cause_out=0, mie_clear=0. Also assert irq during TRAP_RETURN -> ignored, OPERATING next, then the trap is taken if irq is still pending.
